mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port between the instruction-fetch requester (I) and the data-access requester (D).
//  Sits between the IF/MEM pipeline stages and the unified memory/cache.
//  D has fixed priority; a starvation counter forces an I grant when I has waited too long.
//  Adds a per-transaction timeout with error return, plus saturating performance counters.
// PARAMETERS
//  DATA_WIDTH    32   data bus width
//  ADDR_WIDTH    32   address bus width
//  STARVE_LIMIT  4    D grants allowed while I waits before I is forced (>=1)
//  TIMEOUT       255  GRANT cycles without mem_ack before abort (>=1)
//  CNT_WIDTH     16   performance counter width
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           async active-low reset
//  i_req        in   1           fetch request; held with i_addr until i_ack
//  i_addr       in   ADDR_WIDTH  fetch address
//  i_ack        out  1           fetch done (1-cycle pulse)
//  i_rdata      out  DATA_WIDTH  fetch data, valid with i_ack
//  i_err        out  1           fetch aborted by timeout, valid with i_ack
//  d_req        in   1           data request; held with d_addr/d_wdata/d_we until d_ack
//  d_addr       in   ADDR_WIDTH  data address
//  d_wdata      in   DATA_WIDTH  write data
//  d_we         in   1           1 = write
//  d_ack        out  1           data done (1-cycle pulse)
//  d_rdata      out  DATA_WIDTH  read data, valid with d_ack
//  d_err        out  1           data aborted by timeout, valid with d_ack
//  mem_req      out  1           memory request (registered)
//  mem_addr     out  ADDR_WIDTH  memory address (registered)
//  mem_wdata    out  DATA_WIDTH  memory write data (registered)
//  mem_we       out  1           memory write enable (registered)
//  mem_rdata    in   DATA_WIDTH  memory read data
//  mem_ack      in   1           memory completion
//  bus_error    out  1           sticky: any timeout since last err_clr
//  err_clr      in   1           clears bus_error
//  cnt_clr      in   1           clears all counters
//  cnt_i_grants out  CNT_WIDTH   I grants (saturating)
//  cnt_d_grants out  CNT_WIDTH   D grants (saturating)
//  cnt_conflict out  CNT_WIDTH   IDLE decisions with i_req & d_req (saturating)
// BEHAVIOUR
//  - Reset: state IDLE; mem_req/mem_we=0; mem_addr/mem_wdata=0; timer, starve_cnt, counters, bus_error=0.
//  - FSM IDLE -> GRANT_I | GRANT_D; GRANT_x -> IDLE on mem_ack or timeout.
//  - IDLE: if d_req & !(i_req & starve_cnt==STARVE_LIMIT) -> GRANT_D; else if i_req -> GRANT_I; else stay.
//  - Grant entry latches addr/wdata/we (we=0 for I) and sets mem_req=1.
//  - Latency: req in cycle N -> mem_req in N+1. Min 2 cycles/transfer; 1 IDLE bubble after every ack.
//  - GRANT_x: mem_* held stable. x_ack = mem_ack (combinational), x_rdata = mem_rdata, x_err=0.
//    On ack: mem_req=0 next cycle, state -> IDLE.
//  - Non-granted ack/err/rdata = 0. mem_ack in IDLE is ignored.
//  - Timer: clears on grant entry; increments each GRANT cycle without ack. At TIMEOUT-1 without ack:
//    x_ack=1, x_err=1, x_rdata=0, bus_error set, mem_req=0 next cycle, state -> IDLE.
//  - mem_ack coincident with timeout: ack wins, no error.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) on each D grant while i_req=1; cleared on I grant.
//  - Counters: +1 on the relevant IDLE decision, saturating at all-ones. cnt_clr wins over increment.
//  - err_clr same cycle as new timeout: bus_error stays set.
//  - A requester dropping req before ack is illegal; the transaction completes regardless.
//  - Reset mid-transaction abandons it immediately; memory must tolerate mem_req dropping.
// STRUCTURE
//  - cpu_mem_pkg: arb_state_t enum {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}, grant_src_t {SRC_I, SRC_D}.
//  - One sub-module: sat_counter #(CNT_WIDTH) (inc, clr, q), instantiated three times.
//  - FSM, latch registers, timer and starve_cnt live in mem_port_arbiter.
// TESTING
//  1. i_req only, addr 0x1000, mem_ack 2 cycles after mem_req, rdata 0xDEADBEEF
//     -> mem_req at N+1, i_ack with i_rdata=0xDEADBEEF, cnt_i_grants=1.
//  2. i_req & d_req same cycle, d_we=1, d_wdata=0x55 -> D first (mem_we=1, mem_wdata=0x55),
//     then I after the bubble; cnt_conflict=1.
//  3. d_req held continuously with i_req, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D...
//  4. No mem_ack, TIMEOUT=8 -> d_ack & d_err pulse 8 cycles after grant; bus_error=1 until err_clr.
//  5. mem_ack on the timeout cycle -> normal ack, err=0, bus_error stays 0.
//  6. rst_n low during GRANT_D -> mem_req=0 at once, counters 0; after release, pending i_req is served normally.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } grant_src_t;

  // D wins unless I is also waiting and has been passed over the maximum number of times.
  function automatic grant_src_t pick_source(input logic d_req, input logic i_req,
                                             input logic starved);
    if (d_req && !(i_req && starved)) begin
      return SRC_D;
    end else begin
      return SRC_I;
    end
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Count up on inc, stick at all-ones, clear on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      q_r <= {WIDTH{1'b0}};
    end else if (inc && (q_r != {WIDTH{1'b1}})) begin
      q_r <= q_r + WIDTH'(1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D).
// D has fixed priority, a starvation counter eventually forces an I grant,
// and each transaction is aborted with an error if memory never acknowledges.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_we,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  bus_error,
  input  logic                  err_clr,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  cnt_i_grants,
  output logic [CNT_WIDTH-1:0]  cnt_d_grants,
  output logic [CNT_WIDTH-1:0]  cnt_conflict
);

  // Timer only ever needs to reach TIMEOUT-1; keep at least one bit.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t            state_r;
  logic                  mem_req_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  mem_we_r;
  logic [TW-1:0]         timer_r;
  logic [SW-1:0]         starve_cnt_r;
  logic                  bus_error_r;

  logic       idle_s;
  logic       in_grant_s;
  logic       any_req_s;
  logic       starve_full_s;
  logic       timeout_s;
  grant_src_t grant_src_s;
  logic       cnt_i_inc_s;
  logic       cnt_d_inc_s;
  logic       cnt_conf_inc_s;

  // Arbitration decision and timeout detection for the current cycle.
  always_comb begin
    idle_s        = (state_r == ARB_IDLE);
    in_grant_s    = (state_r == ARB_GRANT_I) || (state_r == ARB_GRANT_D);
    any_req_s     = i_req | d_req;
    starve_full_s = (starve_cnt_r == STARVE_MAX);
    grant_src_s   = pick_source(d_req, i_req, starve_full_s);
    // A coincident mem_ack always completes normally, so it masks the timeout.
    timeout_s     = in_grant_s & ~mem_ack & (timer_r == TIMER_LAST);
    cnt_i_inc_s    = idle_s & any_req_s & (grant_src_s == SRC_I);
    cnt_d_inc_s    = idle_s & any_req_s & (grant_src_s == SRC_D);
    cnt_conf_inc_s = idle_s & i_req & d_req;
  end

  // Arbiter FSM: grant entry latches the winner's request onto the memory port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r  <= {DATA_WIDTH{1'b0}};
      mem_we_r     <= 1'b0;
      timer_r      <= {TW{1'b0}};
      starve_cnt_r <= {SW{1'b0}};
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (any_req_s) begin
            mem_req_r <= 1'b1;
            timer_r   <= {TW{1'b0}};
            if (grant_src_s == SRC_D) begin
              state_r     <= ARB_GRANT_D;
              mem_addr_r  <= d_addr;
              mem_wdata_r <= d_wdata;
              mem_we_r    <= d_we;
              if (i_req && !starve_full_s) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
              end
            end else begin
              state_r      <= ARB_GRANT_I;
              mem_addr_r   <= i_addr;
              mem_wdata_r  <= {DATA_WIDTH{1'b0}};
              mem_we_r     <= 1'b0;
              starve_cnt_r <= {SW{1'b0}};
            end
          end
        end
        ARB_GRANT_I, ARB_GRANT_D: begin
          if (mem_ack || timeout_s) begin
            state_r   <= ARB_IDLE;
            mem_req_r <= 1'b0;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flag: a new timeout outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_error_r <= 1'b0;
    end else if (timeout_s) begin
      bus_error_r <= 1'b1;
    end else if (err_clr) begin
      bus_error_r <= 1'b0;
    end else begin
      bus_error_r <= bus_error_r;
    end
  end

  // Route completion back to the granted requester only; abort returns zero data.
  always_comb begin
    i_ack   = 1'b0;
    i_err   = 1'b0;
    i_rdata = {DATA_WIDTH{1'b0}};
    d_ack   = 1'b0;
    d_err   = 1'b0;
    d_rdata = {DATA_WIDTH{1'b0}};
    case (state_r)
      ARB_GRANT_I: begin
        i_ack   = mem_ack | timeout_s;
        i_err   = timeout_s;
        i_rdata = timeout_s ? {DATA_WIDTH{1'b0}} : mem_rdata;
      end
      ARB_GRANT_D: begin
        d_ack   = mem_ack | timeout_s;
        d_err   = timeout_s;
        d_rdata = timeout_s ? {DATA_WIDTH{1'b0}} : mem_rdata;
      end
      default: begin
        i_ack = 1'b0;
        d_ack = 1'b0;
      end
    endcase
  end

  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign bus_error = bus_error_r;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_i_grants (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_i_inc_s),
    .clr   (cnt_clr),
    .q     (cnt_i_grants)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_d_grants (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_d_inc_s),
    .clr   (cnt_clr),
    .q     (cnt_d_grants)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_conflict (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_conf_inc_s),
    .clr   (cnt_clr),
    .q     (cnt_conflict)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_error;
  logic        err_clr;
  logic        cnt_clr;
  logic [15:0] cnt_i_grants;
  logic [15:0] cnt_d_grants;
  logic [15:0] cnt_conflict;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .STARVE_LIMIT (4),
    .TIMEOUT      (8),
    .CNT_WIDTH    (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_rdata      (i_rdata),
    .i_err        (i_err),
    .d_req        (d_req),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_we         (d_we),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .bus_error    (bus_error),
    .err_clr      (err_clr),
    .cnt_clr      (cnt_clr),
    .cnt_i_grants (cnt_i_grants),
    .cnt_d_grants (cnt_d_grants),
    .cnt_conflict (cnt_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic        d_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_i_ack;
    logic        e_i_err;
    logic [31:0] e_i_rdata;
    logic        e_d_ack;
    logic        e_d_err;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic ir, input logic dr, input logic we, input logic ack,
                              input logic [31:0] rd, input logic mr, input logic mw,
                              input logic [31:0] ma, input logic [31:0] mwd,
                              input logic ia, input logic ie, input logic [31:0] ird,
                              input logic da, input logic de, input logic [31:0] drd);
    vec_t v;
    v.i_req = ir; v.d_req = dr; v.d_we = we; v.mem_ack = ack; v.mem_rdata = rd;
    v.e_mem_req = mr; v.e_mem_we = mw; v.e_mem_addr = ma; v.e_mem_wdata = mwd;
    v.e_i_ack = ia; v.e_i_err = ie; v.e_i_rdata = ird;
    v.e_d_ack = da; v.e_d_err = de; v.e_d_rdata = drd;
    return v;
  endfunction

  // Runs one D transaction that never gets an early ack; optionally acks or clears on cycle 8.
  task automatic timeout_case(input string tag, input bit clr_at_to, input bit ack_at_to,
                              input logic exp_bus_err);
    int gc;
    bit seen;
    gc = 0;
    seen = 1'b0;
    d_req = 1'b1;
    d_we = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_req) gc++;
      mem_ack = ack_at_to && (gc == 8);
      err_clr = clr_at_to && (gc == 8);
      @(negedge clk);
      if (d_ack) begin
        seen = 1'b1;
        check({tag, "_ack_cycle"}, 32'(gc), 32'd8);
        check({tag, "_d_err"}, {31'd0, d_err}, {31'd0, !ack_at_to});
        check({tag, "_d_rdata"}, d_rdata, ack_at_to ? 32'hA5A5_A5A5 : 32'h0);
      end
    end
    if (!seen) check({tag, "_ack_seen"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    mem_ack = 1'b0;
    err_clr = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    check({tag, "_mem_req_drop"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_bus_error"}, {31'd0, bus_error}, {31'd0, exp_bus_err});
  endtask

  logic [5:0] got;
  int         n;
  logic       prev;

  initial begin
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = 32'h1000;
    d_req = 1'b0; d_addr = 32'h2000; d_wdata = 32'h55; d_we = 1'b0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    err_clr = 1'b0; cnt_clr = 1'b0;

    // Single I fetch with a 2-cycle memory, then simultaneous D write and I fetch.
    vecs[0] = mk(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0,  0, 0, 32'h0,        0, 0, 32'h0);
    vecs[1] = mk(1, 0, 0, 0, 32'h0,        1, 0, 32'h1000, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0);
    vecs[2] = mk(1, 0, 0, 0, 32'h0,        1, 0, 32'h1000, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0);
    vecs[3] = mk(1, 0, 0, 1, 32'hDEADBEEF, 1, 0, 32'h1000, 32'h0,  1, 0, 32'hDEADBEEF, 0, 0, 32'h0);
    vecs[4] = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h1000, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0);
    vecs[5] = mk(1, 1, 1, 0, 32'h0,        0, 0, 32'h1000, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0);
    vecs[6] = mk(1, 1, 1, 1, 32'h12345678, 1, 1, 32'h2000, 32'h55, 0, 0, 32'h0,        1, 0, 32'h12345678);
    vecs[7] = mk(1, 0, 0, 0, 32'h0,        0, 1, 32'h2000, 32'h55, 0, 0, 32'h0,        0, 0, 32'h0);
    vecs[8] = mk(1, 0, 0, 1, 32'hCAFEF00D, 1, 0, 32'h1000, 32'h0,  1, 0, 32'hCAFEF00D, 0, 0, 32'h0);
    vecs[9] = mk(0, 0, 0, 0, 32'h0,        0, 0, 32'h1000, 32'h0,  0, 0, 32'h0,        0, 0, 32'h0);

    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cnt_i", {16'd0, cnt_i_grants}, 32'd0);
    check("rst_bus_error", {31'd0, bus_error}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      i_req = vecs[k].i_req;
      d_req = vecs[k].d_req;
      d_we = vecs[k].d_we;
      mem_ack = vecs[k].mem_ack;
      mem_rdata = vecs[k].mem_rdata;
      @(negedge clk);
      check($sformatf("v%0d_mem_req", k), {31'd0, mem_req}, {31'd0, vecs[k].e_mem_req});
      check($sformatf("v%0d_mem_we", k), {31'd0, mem_we}, {31'd0, vecs[k].e_mem_we});
      check($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].e_mem_addr);
      check($sformatf("v%0d_mem_wdata", k), mem_wdata, vecs[k].e_mem_wdata);
      check($sformatf("v%0d_i_ack", k), {31'd0, i_ack}, {31'd0, vecs[k].e_i_ack});
      check($sformatf("v%0d_i_err", k), {31'd0, i_err}, {31'd0, vecs[k].e_i_err});
      check($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].e_i_rdata);
      check($sformatf("v%0d_d_ack", k), {31'd0, d_ack}, {31'd0, vecs[k].e_d_ack});
      check($sformatf("v%0d_d_err", k), {31'd0, d_err}, {31'd0, vecs[k].e_d_err});
      check($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].e_d_rdata);
    end
    check("tbl_cnt_i", {16'd0, cnt_i_grants}, 32'd2);
    check("tbl_cnt_d", {16'd0, cnt_d_grants}, 32'd1);
    check("tbl_cnt_conflict", {16'd0, cnt_conflict}, 32'd1);

    // Starvation: both held, memory acks immediately; expect D,D,D,D,I,D.
    got = 6'b0;
    n = 0;
    prev = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(posedge clk); #1;
      mem_ack = mem_req;
      mem_rdata = 32'h0;
      @(negedge clk);
      if (mem_req && !prev) begin
        got[n] = (mem_addr == 32'h2000);
        n++;
      end
      prev = mem_req;
    end
    check("starve_grant_count", 32'(n), 32'd6);
    check("starve_order", {26'd0, got}, {26'd0, 6'b101111});
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    check("starve_cnt_i", {16'd0, cnt_i_grants}, 32'd3);
    check("starve_cnt_d", {16'd0, cnt_d_grants}, 32'd6);
    check("starve_cnt_conflict", {16'd0, cnt_conflict}, 32'd7);

    // Timeout with error, stickiness and clear.
    timeout_case("to", 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("to_sticky", {31'd0, bus_error}, 32'd1);
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    check("to_err_clr", {31'd0, bus_error}, 32'd0);

    // Ack on the timeout cycle wins; then clear coincident with a timeout loses.
    timeout_case("ack_at_to", 1'b0, 1'b1, 1'b0);
    timeout_case("clr_at_to", 1'b1, 1'b0, 1'b1);

    // cnt_clr on the same cycle as an I grant decision clears everything.
    @(posedge clk); #1; i_req = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_1111;
    @(negedge clk);
    check("clr_cnt_i", {16'd0, cnt_i_grants}, 32'd0);
    check("clr_cnt_d", {16'd0, cnt_d_grants}, 32'd0);
    check("clr_cnt_conflict", {16'd0, cnt_conflict}, 32'd0);
    check("clr_i_ack", {31'd0, i_ack}, 32'd1);
    @(posedge clk); #1; i_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;

    // Reset in the middle of a D grant, with I pending.
    @(posedge clk); #1; d_req = 1'b1; d_we = 1'b1;
    @(posedge clk); #1; i_req = 1'b1;
    @(negedge clk);
    check("mid_mem_req", {31'd0, mem_req}, 32'd1);
    check("mid_mem_we", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_req", {31'd0, mem_req}, 32'd0);
    check("async_mem_addr", mem_addr, 32'h0);
    check("async_cnt_d", {16'd0, cnt_d_grants}, 32'd0);
    check("async_bus_error", {31'd0, bus_error}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    check("post_rst_mem_addr", mem_addr, 32'h1000);
    check("post_rst_i_ack", {31'd0, i_ack}, 32'd1);
    check("post_rst_i_rdata", i_rdata, 32'h0BAD_F00D);
    @(posedge clk); #1; i_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("post_rst_idle", {31'd0, mem_req}, 32'd0);
    check("post_rst_cnt_i", {16'd0, cnt_i_grants}, 32'd1);
    check("post_rst_cnt_conflict", {16'd0, cnt_conflict}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
